// File: rtl/uart_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t : scheduler FSM states. TAG_LOAD/TAG_WAIT are only reached
//                   when the design is built with UART_SCHED_TAG_EN defined.
//   TAG_PREFIX    : upper nibble of the tag byte sent ahead of each data byte.
// ---------------------------------------------------------------------------
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        TAG_LOAD,
        TAG_WAIT,
        LOAD,
        WAIT_DONE,
        GAP
    } sched_state_t;

    localparam logic [3:0] TAG_PREFIX = 4'hA;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the client request side and the UART transmitter side of the
// scheduler.
//   req_valid/req_data/req_ready : per-source byte handshake (slice i of
//                                  req_data is source i's byte)
//   tx_ready/tx_done             : transmitter status
//   tx_start/tx_data             : frame launch towards the transmitter
//   grant_id/sched_busy/err_timeout : scheduler status
// Modports:
//   master : the scheduler itself
//   slave  : the surrounding logic (clients + transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_ready;
    logic               tx_done;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic [IDW-1:0]     grant_id;
    logic               sched_busy;
    logic               err_timeout;

    modport master (
        input  req_valid, req_data, tx_ready, tx_done,
        output req_ready, tx_start, tx_data, grant_id, sched_busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, tx_ready, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, sched_busy, err_timeout
    );

endinterface

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Scans sources last_grant+1, +2, ...
// (mod N_REQ) and returns the first one with its request bit set.
//   i_req        : request vector, one bit per source
//   i_last_grant : source granted most recently
//   o_grant      : chosen source (i_last_grant when nothing is requesting)
//   o_any_valid  : at least one request bit is set
// ---------------------------------------------------------------------------
module uart_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_last_grant,
    output logic [IDW-1:0]   o_grant,
    output logic             o_any_valid
);

    logic [IDW-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        o_grant     = i_last_grant;
        o_any_valid = 1'b0;
        w_cand      = i_last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            // Explicit wrap keeps the scan correct for non-power-of-two N_REQ.
            if (w_cand == IDW'(N_REQ - 1)) begin
                w_cand = '0;
            end else begin
                w_cand = w_cand + 1'b1;
            end
            if (!o_any_valid && i_req[w_cand]) begin
                o_grant     = w_cand;
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART byte transmitter between N_REQ byte sources. A round-robin
// arbiter captures one byte, the FSM launches it with a 1-cycle tx_start,
// waits for tx_done under a watchdog, then enforces an idle gap before the
// next arbitration.
// Ports:
//   clk  : system clock, posedge
//   rst  : asynchronous, active-low reset
//   bus  : uart_tx_scheduler_if.master (request handshake, transmitter
//          control, status outputs)
// Parameters:
//   N_REQ          : number of sources, 2..16
//   GAP_CYCLES     : idle cycles forced after each frame, >= 1
//   TIMEOUT_CYCLES : cycles allowed from tx_start to tx_done, >= 2
// Build option:
//   UART_SCHED_TAG_EN : when defined, every data byte is preceded by a tag
//                       byte {4'hA, grant_id}. A tag-frame timeout drops the
//                       (already acknowledged) data byte.
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic clk,
    input logic rst,
    uart_tx_scheduler_if.master bus
);

    localparam int IDW = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    sched_state_t   r_state;
    sched_state_t   w_next;

    logic [IDW-1:0] r_last_grant;
    logic [IDW-1:0] r_grant_id;
    logic [7:0]     r_tx_data;
    logic [WDW-1:0] r_wdog;
    logic [GCW-1:0] r_gap;
`ifdef UART_SCHED_TAG_EN
    logic [7:0]     r_data_byte;
    logic           w_load_data;
`endif

    logic [IDW-1:0]   w_grant;
    logic             w_any_valid;
    logic [7:0]       w_sel_byte;
    logic [N_REQ-1:0] w_req_ready;
    logic             w_capture;
    logic             w_tx_start;
    logic             w_err_timeout;
    logic             w_in_wait;
    logic             w_wdog_exp;
    logic             w_gap_last;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_valid  (w_any_valid)
    );

    // Byte mux and one-hot acknowledge for the picked source.
    always_comb begin
        w_sel_byte  = '0;
        w_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_byte     = bus.req_data[8*i +: 8];
                w_req_ready[i] = w_capture;
            end
        end
    end

`ifdef UART_SCHED_TAG_EN
    assign w_in_wait = (r_state == WAIT_DONE) || (r_state == TAG_WAIT);
`else
    assign w_in_wait = (r_state == WAIT_DONE);
`endif
    assign w_wdog_exp = (r_wdog == WDW'(TIMEOUT_CYCLES - 1));
    assign w_gap_last = (r_gap == GCW'(GAP_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_tx_start    = 1'b0;
        w_err_timeout = 1'b0;
`ifdef UART_SCHED_TAG_EN
        w_load_data   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) w_next = ARB;
            end
            ARB: begin
                if (w_any_valid) begin
                    w_capture = 1'b1;
`ifdef UART_SCHED_TAG_EN
                    w_next    = TAG_LOAD;
`else
                    w_next    = LOAD;
`endif
                end else begin
                    w_next = IDLE;
                end
            end
`ifdef UART_SCHED_TAG_EN
            TAG_LOAD: begin
                if (bus.tx_ready) begin
                    w_tx_start = 1'b1;
                    w_next     = TAG_WAIT;
                end
            end
            TAG_WAIT: begin
                // tx_done is tested first so it wins over a same-cycle expiry.
                if (bus.tx_done) begin
                    w_load_data = 1'b1;
                    w_next      = LOAD;
                end else if (w_wdog_exp) begin
                    w_err_timeout = 1'b1;
                    w_next        = GAP;
                end
            end
`endif
            LOAD: begin
                if (bus.tx_ready) begin
                    w_tx_start = 1'b1;
                    w_next     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // tx_done is tested first so it wins over a same-cycle expiry.
                if (bus.tx_done) begin
                    w_next = GAP;
                end else if (w_wdog_exp) begin
                    w_err_timeout = 1'b1;
                    w_next        = GAP;
                end
            end
            GAP: begin
                if (w_gap_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture registers, watchdog and gap counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= IDW'(N_REQ - 1);
            r_grant_id   <= '0;
            r_tx_data    <= '0;
            r_wdog       <= '0;
            r_gap        <= '0;
`ifdef UART_SCHED_TAG_EN
            r_data_byte  <= '0;
`endif
        end else begin
            if (w_capture) begin
                r_grant_id   <= w_grant;
                r_last_grant <= w_grant;
`ifdef UART_SCHED_TAG_EN
                r_tx_data    <= {TAG_PREFIX, 4'(w_grant)};
                r_data_byte  <= w_sel_byte;
`else
                r_tx_data    <= w_sel_byte;
`endif
            end
`ifdef UART_SCHED_TAG_EN
            if (w_load_data) r_tx_data <= r_data_byte;
`endif
            // Watchdog restarts on every launch and saturates at expiry.
            if (w_tx_start) begin
                r_wdog <= '0;
            end else if (w_in_wait && !w_wdog_exp) begin
                r_wdog <= r_wdog + 1'b1;
            end
            // Gap counter is held at zero outside GAP so each gap starts clean.
            if (r_state != GAP) begin
                r_gap <= '0;
            end else if (!w_gap_last) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.tx_start    = w_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.sched_busy  = (r_state != IDLE);
    assign bus.err_timeout = w_err_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler. u_dut uses default parameters;
// u_dut_wd uses TIMEOUT_CYCLES=8 for the watchdog scenarios. With
// UART_SCHED_TAG_EN defined only the reset and tag-frame scenarios run.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int DONE_LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler_if #(.N_REQ(4)) bus ();
    uart_tx_scheduler_if #(.N_REQ(4)) wd ();

    uart_tx_scheduler #(.N_REQ(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    uart_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(8)) u_dut_wd (
        .clk (clk),
        .rst (rst),
        .bus (wd)
    );

    // Client / transmitter model for u_dut.
    int         pend_cnt [4];
    logic [7:0] pend_data [4];
    logic       tx_ready_v = 1'b1;
    logic       auto_done  = 1'b0;
    int         done_at    = -100;
    int         st_cyc[$];
    int         st_data[$];
    int         st_gid[$];
    int         rr_cyc[$];
    int         rr_idx[$];
    int         err_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Drive at the falling edge, sample 2 ns later; the DUT acts on the next rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]       = (pend_cnt[i] > 0);
            bus.req_data[8*i +: 8] = pend_data[i];
        end
        bus.tx_ready = tx_ready_v;
        bus.tx_done  = auto_done && (cyc == done_at);
        #2;
        if (bus.tx_start) begin
            st_cyc.push_back(cyc);
            st_data.push_back(int'(bus.tx_data));
            st_gid.push_back(int'(bus.grant_id));
            done_at = cyc + DONE_LAT;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.req_ready[i]) begin
                rr_cyc.push_back(cyc);
                rr_idx.push_back(i);
                if (pend_cnt[i] > 0) pend_cnt[i]--;
            end
        end
        if (bus.err_timeout) err_cyc.push_back(cyc);
    end

    task automatic clear_log();
        st_cyc.delete(); st_data.delete(); st_gid.delete();
        rr_cyc.delete(); rr_idx.delete(); err_cyc.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(posedge clk); #1;
        while (bus.sched_busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", bus.sched_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0;
        int bad;
        int wd_cnt [2];
        int wst[$];
        int werr[$];
        int wrr[$];
        int wgid;
        int s2;

        for (int i = 0; i < 4; i++) begin
            pend_cnt[i]  = 0;
            pend_data[i] = 8'h00;
        end
        wd.req_valid = '0;
        wd.req_data  = '0;
        wd.tx_ready  = 1'b1;
        wd.tx_done   = 1'b0;

        // Reset state.
        wait_cycles(3);
        check("rst_outs", {bus.req_ready, bus.tx_start, bus.sched_busy, bus.err_timeout}, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_grant_id", bus.grant_id, 0);
        rst = 1'b1;
        wait_cycles(2);
        check("post_rst_busy", bus.sched_busy, 1'b0);

`ifdef UART_SCHED_TAG_EN
        // Tag frame then data frame from source 2.
        clear_log();
        auto_done = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        pend_data[2] = 8'h7E;
        pend_cnt[2]  = 1;
        wait_cycles(30);
        wait_idle(64);
        check("tag_starts", st_cyc.size(), 2);
        check("tag_byte", qget(st_data, 0), 8'hA2);
        check("tag_start_cyc", qget(st_cyc, 0), c0 + 2);
        check("tag_data_byte", qget(st_data, 1), 8'h7E);
        check("tag_data_cyc", qget(st_cyc, 1), c0 + 3 + DONE_LAT);
        check("tag_rr_count", rr_cyc.size(), 1);
        check("tag_rr_idx", qget(rr_idx, 0), 2);
        check("tag_err", err_cyc.size(), 0);
`else
        // Single source: ack at +1, launch at +2.
        clear_log();
        auto_done = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        pend_data[0] = 8'h55;
        pend_cnt[0]  = 1;
        wait_cycles(20);
        check("t1_rr_cyc", qget(rr_cyc, 0), c0 + 1);
        check("t1_rr_idx", qget(rr_idx, 0), 0);
        check("t1_rr_count", rr_cyc.size(), 1);
        check("t1_start_cyc", qget(st_cyc, 0), c0 + 2);
        check("t1_data", qget(st_data, 0), 8'h55);
        check("t1_data_hold", bus.tx_data, 8'h55);
        check("t1_gap_busy", bus.sched_busy, 1'b1);
        wait_idle(64);

        // Reset in WAIT_DONE: outputs clear at once.
        clear_log();
        auto_done = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        pend_data[1] = 8'h3C;
        pend_cnt[1]  = 1;
        wait_cycles(5);
        check("t5_busy_before", bus.sched_busy, 1'b1);
        check("t5_gid_before", bus.grant_id, 1);
        rst = 1'b0;
        #1;
        check("t5_rst_outs", {bus.req_ready, bus.tx_start, bus.sched_busy, bus.err_timeout}, 0);
        check("t5_rst_data", bus.tx_data, 8'h00);
        check("t5_rst_gid", bus.grant_id, 0);
        for (int i = 0; i < 4; i++) pend_cnt[i] = 0;
        done_at = -100;
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(2);

        // All four valid: order 0,1,2,3,0 with 29-cycle frame spacing.
        clear_log();
        auto_done = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) pend_data[i] = 8'h10 + 8'(i);
        pend_cnt[0] = 2;
        pend_cnt[1] = 1;
        pend_cnt[2] = 1;
        pend_cnt[3] = 1;
        bad = 0;
        while (st_cyc.size() < 5 && bad < 400) begin
            @(posedge clk); #1;
            bad++;
        end
        wait_idle(64);
        begin
            int exp_gid [5] = '{0, 1, 2, 3, 0};
            for (int j = 0; j < 5; j++) begin
                check($sformatf("t2_gid%0d", j), qget(st_gid, j), exp_gid[j]);
                check($sformatf("t2_data%0d", j), qget(st_data, j), 8'h10 + exp_gid[j]);
                check($sformatf("t2_start%0d", j), qget(st_cyc, j), c0 + 2 + j * (DONE_LAT + 16 + 3));
            end
        end
        check("t2_rr_count", rr_cyc.size(), 5);

        // tx_ready low for 20 LOAD cycles.
        clear_log();
        tx_ready_v = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        pend_data[2] = 8'hC3;
        pend_cnt[2]  = 1;
        bad = 0;
        while (cyc < c0 + 21) begin
            @(negedge clk); #3;
            if (cyc >= c0 + 2 && bus.tx_data !== 8'hC3) bad++;
        end
        check("t3_no_early_start", st_cyc.size(), 0);
        tx_ready_v = 1'b1;
        wait_cycles(3);
        check("t3_start_cyc", qget(st_cyc, 0), c0 + 22);
        check("t3_data_stable", bad, 0);
        check("t3_data", qget(st_data, 0), 8'hC3);
        wait_idle(64);
        check("t3_gid_hold", bus.grant_id, 2);

        // Watchdog on u_dut_wd: frame 0 expires, frame 1 has tx_done on the expiry cycle.
        wd_cnt[0] = 1;
        wd_cnt[1] = 1;
        wd.req_data = {8'h00, 8'h00, 8'hB2, 8'hA5};
        wgid = -1;
        s2 = -100;
        @(posedge clk); #1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            wd.req_valid = {2'b00, wd_cnt[1] > 0, wd_cnt[0] > 0};
            wd.tx_done   = (cyc == s2 + 8);
            #2;
            if (wd.tx_start) begin
                wst.push_back(cyc);
                if (wst.size() == 2) begin
                    s2   = cyc;
                    wgid = int'(wd.grant_id);
                end
            end
            if (wd.err_timeout) werr.push_back(cyc);
            for (int i = 0; i < 2; i++) begin
                if (wd.req_ready[i]) begin
                    wrr.push_back(i);
                    wd_cnt[i] = 0;
                end
            end
        end
        check("wd_err_count", werr.size(), 1);
        check("wd_err_after_start", qget(werr, 0) - qget(wst, 0), 8);
        check("wd_next_start", qget(wst, 1) - qget(werr, 0), 19);
        check("wd_second_gid", wgid, 1);
        check("wd_rr_order", {qget(wrr, 0), qget(wrr, 1)}, {32'd0, 32'd1});
        check("wd_idle_end", wd.sched_busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
